// File: rtl/timer_ctrl_master_pkg.sv
// Register map, control bits and FSM state encoding for the interval-timer
// bus master.
package timer_ctrl_master_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [15:0] CTRL_STOP_WORD = 16'h0001 << CTRL_STOP;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_RUN,
    ST_CLR_ST,
    ST_STOP,
    ST_SNAP_WR,
    ST_RD_L,
    ST_RD_H
  } state_t;

  function automatic logic [15:0] ctrl_start_word(input logic continuous);
    logic [15:0] w;
    w             = '0;
    w[CTRL_ITO]   = 1'b1;
    w[CTRL_CONT]  = continuous;
    w[CTRL_START] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs the interval timer, services its timeouts
// and reads 32-bit counter snapshots on behalf of a hardware sequencer.
//
// state      | meaning
// IDLE       | timer not owned, waiting for cfg_start
// WR_PL      | writing period[15:0]
// WR_PH      | writing period[31:16]
// WR_CTRL    | writing START|CONT|ITO
// RUN        | timer counting, watching irq / stop / snapshot
// CLR_ST     | clearing status after a timeout
// STOP       | writing STOP to control
// SNAP_WR    | latching counter into snap registers
// RD_L/RD_H  | reading snap low / high half
module timer_ctrl_master
  import timer_ctrl_master_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int TICK_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              snap_req,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  input  logic              irq,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  state_t            state, state_nx;
  logic [31:0]       period, period_nx;
  logic              continuous, continuous_nx;
  logic [TICK_W-1:0] tick_count_nx;
  logic [15:0]       snap_lo, snap_lo_nx;
  logic [31:0]       snap_value_nx;
  logic              snap_valid_nx, tick_nx;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nx;
  logic [2:0]        address_nx;
  logic              chipselect_nx, write_n_nx, read_nx;
  logic [15:0]       writedata_nx;
  logic              accepted, issue;

  assign accepted = avm_chipselect && !avm_waitrequest;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      period         <= '0;
      continuous     <= 1'b0;
      tick_count     <= '0;
      snap_lo        <= '0;
      snap_value     <= '0;
      snap_valid     <= 1'b0;
      tick           <= 1'b0;
      lat_cnt        <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read       <= 1'b0;
      avm_writedata  <= '0;
    end else begin
      state          <= state_nx;
      period         <= period_nx;
      continuous     <= continuous_nx;
      tick_count     <= tick_count_nx;
      snap_lo        <= snap_lo_nx;
      snap_value     <= snap_value_nx;
      snap_valid     <= snap_valid_nx;
      tick           <= tick_nx;
      lat_cnt        <= lat_cnt_nx;
      avm_address    <= address_nx;
      avm_chipselect <= chipselect_nx;
      avm_write_n    <= write_n_nx;
      avm_read       <= read_nx;
      avm_writedata  <= writedata_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    period_nx     = period;
    continuous_nx = continuous;
    tick_count_nx = tick_count;
    snap_lo_nx    = snap_lo;
    snap_value_nx = snap_value;
    snap_valid_nx = 1'b0;
    tick_nx       = 1'b0;
    lat_cnt_nx    = lat_cnt;
    address_nx    = avm_address;
    chipselect_nx = avm_chipselect;
    write_n_nx    = avm_write_n;
    read_nx       = avm_read;
    writedata_nx  = avm_writedata;
    issue         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cfg_start && (cfg_period != 32'd0)) begin
          period_nx     = cfg_period;
          continuous_nx = cfg_continuous;
          tick_count_nx = '0;
          state_nx      = ST_WR_PL;
          issue         = 1'b1;
        end
      end
      ST_WR_PL:   if (accepted) begin state_nx = ST_WR_PH;   issue = 1'b1; end
      ST_WR_PH:   if (accepted) begin state_nx = ST_WR_CTRL; issue = 1'b1; end
      ST_WR_CTRL: if (accepted) begin state_nx = ST_RUN;     issue = 1'b1; end
      ST_RUN: begin
        // Only the highest-priority request is taken; the others are dropped.
        if (irq) begin
          state_nx = ST_CLR_ST;
          issue    = 1'b1;
        end else if (cfg_stop) begin
          state_nx = ST_STOP;
          issue    = 1'b1;
        end else if (snap_req) begin
          state_nx = ST_SNAP_WR;
          issue    = 1'b1;
        end
      end
      ST_CLR_ST: begin
        if (accepted) begin
          tick_nx       = 1'b1;
          tick_count_nx = tick_count + TICK_W'(1);
          state_nx      = continuous ? ST_RUN : ST_IDLE;
          issue         = 1'b1;
        end
      end
      ST_STOP:    if (accepted) begin state_nx = ST_IDLE; issue = 1'b1; end
      ST_SNAP_WR: if (accepted) begin state_nx = ST_RD_L; issue = 1'b1; end
      ST_RD_L, ST_RD_H: begin
        // Strobes high = address phase; low = waiting out the read latency.
        if (avm_chipselect) begin
          if (!avm_waitrequest) begin
            chipselect_nx = 1'b0;
            read_nx       = 1'b0;
            lat_cnt_nx    = LAT_W'(READ_LATENCY);
          end
        end else if (lat_cnt == LAT_W'(1)) begin
          if (state == ST_RD_L) begin
            snap_lo_nx = avm_readdata;
            state_nx   = ST_RD_H;
          end else begin
            snap_value_nx = {avm_readdata, snap_lo};
            snap_valid_nx = 1'b1;
            state_nx      = ST_RUN;
          end
          issue = 1'b1;
        end else begin
          lat_cnt_nx = lat_cnt - LAT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (issue) begin
      chipselect_nx = 1'b0;
      write_n_nx    = 1'b1;
      read_nx       = 1'b0;
      case (state_nx)
        ST_WR_PL: begin
          chipselect_nx = 1'b1; write_n_nx = 1'b0;
          address_nx = REG_PERIOD_L; writedata_nx = period_nx[15:0];
        end
        ST_WR_PH: begin
          chipselect_nx = 1'b1; write_n_nx = 1'b0;
          address_nx = REG_PERIOD_H; writedata_nx = period_nx[31:16];
        end
        ST_WR_CTRL: begin
          chipselect_nx = 1'b1; write_n_nx = 1'b0;
          address_nx = REG_CONTROL; writedata_nx = ctrl_start_word(continuous_nx);
        end
        ST_CLR_ST: begin
          chipselect_nx = 1'b1; write_n_nx = 1'b0;
          address_nx = REG_STATUS; writedata_nx = 16'h0000;
        end
        ST_STOP: begin
          chipselect_nx = 1'b1; write_n_nx = 1'b0;
          address_nx = REG_CONTROL; writedata_nx = CTRL_STOP_WORD;
        end
        ST_SNAP_WR: begin
          chipselect_nx = 1'b1; write_n_nx = 1'b0;
          address_nx = REG_SNAP_L; writedata_nx = 16'h0000;
        end
        ST_RD_L: begin
          chipselect_nx = 1'b1; read_nx = 1'b1; address_nx = REG_SNAP_L;
        end
        ST_RD_H: begin
          chipselect_nx = 1'b1; read_nx = 1'b1; address_nx = REG_SNAP_H;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Directed bench for timer_ctrl_master against a small behavioural model of
// the interval timer's s1 register port.
module tb_timer_ctrl_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] cfg_period = '0;
  logic        cfg_continuous = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic        snap_req = 1'b0;
  logic        busy, tick, snap_valid, irq;
  logic [15:0] tick_count;
  logic [31:0] snap_value;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n, avm_read;
  logic [15:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  timer_ctrl_master #(.READ_LATENCY(1), .TICK_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .snap_req(snap_req),
    .busy(busy), .tick(tick), .tick_count(tick_count),
    .snap_value(snap_value), .snap_valid(snap_valid), .irq(irq),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer model: not reset by reset_n, like the real peripheral.
  logic [15:0] m_period_l = '0, m_period_h = '0, m_snap_l = '0, m_snap_h = '0;
  logic [15:0] m_rdata = '0;
  logic [31:0] m_count = '0;
  logic        m_run = 1'b0, m_cont = 1'b0, m_ito = 1'b0, m_to = 1'b0;
  logic        hold = 1'b0, load_cnt = 1'b0, force_to = 1'b0, clear_to = 1'b0;
  logic        rand_wait = 1'b0;
  logic [31:0] load_val = '0;
  logic [18:0] wlog[$];
  logic [2:0]  rlog[$];

  assign irq          = m_to & m_ito;
  assign avm_readdata = m_rdata;

  wire wr_acc = avm_chipselect && !avm_write_n && !avm_waitrequest;
  wire rd_acc = avm_chipselect && avm_read && !avm_waitrequest;

  always @(posedge clk) begin
    if (load_cnt) m_count <= load_val;
    else if (m_run && !hold) begin
      if (m_count == 0) begin
        m_to    <= 1'b1;
        m_count <= {m_period_h, m_period_l};
        if (!m_cont) m_run <= 1'b0;
      end else m_count <= m_count - 1;
    end
    if (force_to) m_to <= 1'b1;
    if (clear_to) m_to <= 1'b0;
    if (wr_acc) begin
      wlog.push_back({avm_address, avm_writedata});
      case (avm_address)
        3'd0: m_to <= 1'b0;
        3'd1: begin
          m_ito  <= avm_writedata[0];
          m_cont <= avm_writedata[1];
          if (avm_writedata[2]) m_run <= 1'b1;
          if (avm_writedata[3]) m_run <= 1'b0;
        end
        3'd2: begin m_period_l <= avm_writedata; m_count <= {m_period_h, avm_writedata}; m_run <= 1'b0; end
        3'd3: begin m_period_h <= avm_writedata; m_count <= {avm_writedata, m_period_l}; m_run <= 1'b0; end
        3'd4: {m_snap_h, m_snap_l} <= m_count;
        default: ;
      endcase
    end
    if (rd_acc) begin
      rlog.push_back(avm_address);
      m_rdata <= (avm_address == 3'd4) ? m_snap_l : (avm_address == 3'd5) ? m_snap_h : 16'h0000;
    end
  end

  always @(negedge clk) avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;

  // Bus stability while stalled
  int          stall_err = 0, stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [21:0] prev_bus = '0;
  always @(posedge clk) begin
    if (prev_stall && ({avm_chipselect, avm_write_n, avm_read, avm_address, avm_writedata} !== prev_bus))
      stall_err <= stall_err + 1;
    if (avm_chipselect && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    prev_stall <= avm_chipselect && avm_waitrequest;
    prev_bus   <= {avm_chipselect, avm_write_n, avm_read, avm_address, avm_writedata};
  end

  function automatic logic [18:0] we(input logic [2:0] a, input logic [15:0] d);
    return {a, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return tick === 1'b1;
      1:       return snap_valid === 1'b1;
      2:       return irq === 1'b1;
      default: return busy === 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string tag, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!cond(sel) && n < budget);
    if (!cond(sel)) begin
      checks++;
      errors++;
      $error("FAIL %s: timeout after %0d cycles", tag, n);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [31:0] p, input logic c);
    cfg_period = p; cfg_continuous = c; cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
  endtask

  task automatic stop_pulse();
    cfg_stop = 1'b1;
    step(1);
    cfg_stop = 1'b0;
  endtask

  initial begin
    int n, t1, t2, t3, found;
    #2 reset_n = 1'b0;
    step(2);
    check("rst busy", busy, 0);
    check("rst strobes", {avm_chipselect, avm_read, avm_write_n, tick, snap_valid}, 5'b00100);
    check("rst addr/data", {avm_address, avm_writedata}, 0);
    check("rst tick_count", tick_count, 0);
    check("rst snap_value", snap_value, 0);
    reset_n = 1'b1;
    step(2);

    // Continuous, period 0x31
    wlog.delete();
    start(32'h0000_0031, 1'b1);
    check("t1 busy", busy, 1);
    wait_for(0, 200, "t1 tick1", n); t1 = cyc;
    wait_for(0, 200, "t1 tick2", n); t2 = cyc;
    wait_for(0, 200, "t1 tick3", n); t3 = cyc;
    check("t1 tick_count", tick_count, 3);
    check("t1 spacing a", t2 - t1, 50);
    check("t1 spacing b", t3 - t2, 50);
    check("t1 wr0", wlog[0], we(3'd2, 16'h0031));
    check("t1 wr1", wlog[1], we(3'd3, 16'h0000));
    check("t1 wr2", wlog[2], we(3'd1, 16'h0007));
    check("t1 wr3", wlog[3], we(3'd0, 16'h0000));
    stop_pulse();
    wait_for(3, 10, "t1 stop", n);
    check("t1 stop word", wlog[wlog.size() - 1], we(3'd1, 16'h0008));

    // One-shot, period 10
    wlog.delete();
    start(32'd10, 1'b0);
    wait_for(0, 60, "t2 tick", n);
    check("t2 tick_count", tick_count, 1);
    check("t2 ctrl word", wlog[2], we(3'd1, 16'h0005));
    step(1);
    check("t2 idle", busy, 0);
    force_to = 1'b1; step(1); force_to = 1'b0;
    step(10);
    check("t2 irq ignored count", tick_count, 1);
    check("t2 irq ignored busy", busy, 0);
    clear_to = 1'b1; step(1); clear_to = 1'b0;

    // Snapshot
    wlog.delete();
    snap_req = 1'b1; step(1); snap_req = 1'b0;
    step(3);
    check("t3 snap in idle", {busy, 8'(wlog.size())}, 0);
    start(32'h0010_0000, 1'b1);
    step(6);
    load_val = 32'h0001_2345; load_cnt = 1'b1; hold = 1'b1;
    step(1);
    load_cnt = 1'b0;
    wlog.delete(); rlog.delete();
    snap_req = 1'b1; step(1); snap_req = 1'b0;
    wait_for(1, 20, "t3 snap_valid", n);
    check("t3 latency", n + 1, 6);
    check("t3 snap_value", snap_value, 32'h0001_2345);
    check("t3 wr", {8'(wlog.size()), 13'd0, wlog[0]}, {8'd1, 13'd0, we(3'd4, 16'h0000)});
    check("t3 rd", {8'(rlog.size()), 5'd0, rlog[0], 5'd0, rlog[1]}, {8'd2, 8'd4, 8'd5});
    step(1);
    check("t3 snap_valid pulse", {snap_valid, busy}, 2'b01);
    hold = 1'b0;
    stop_pulse();
    wait_for(3, 10, "t3 stop", n);

    // Same-cycle irq and stop
    start(32'h0000_0031, 1'b1);
    wait_for(2, 100, "t4 irq", n);
    wlog.delete();
    stop_pulse();
    wait_for(0, 5, "t4 tick", n);
    check("t4 tick_count", tick_count, 1);
    step(3);
    check("t4 still busy", busy, 1);
    found = 0;
    foreach (wlog[i]) if (wlog[i] == we(3'd1, 16'h0008)) found++;
    check("t4 stop dropped", found, 0);
    wait_for(0, 60, "t4 tick2", n);
    check("t4 tick_count2", tick_count, 2);
    stop_pulse();
    wait_for(3, 10, "t4 stop", n);

    // Random waitrequest
    rand_wait = 1'b1;
    wlog.delete();
    start(32'h0000_0031, 1'b1);
    wait_for(0, 300, "t5 tick1", n);
    wait_for(0, 300, "t5 tick2", n);
    check("t5 tick_count", tick_count, 2);
    stop_pulse();
    wait_for(3, 40, "t5 stop", n);
    rand_wait = 1'b0;
    check("t5 wr count", wlog.size(), 6);
    check("t5 wr0", wlog[0], we(3'd2, 16'h0031));
    check("t5 wr1", wlog[1], we(3'd3, 16'h0000));
    check("t5 wr2", wlog[2], we(3'd1, 16'h0007));
    check("t5 wr3", wlog[3], we(3'd0, 16'h0000));
    check("t5 wr5", wlog[5], we(3'd1, 16'h0008));
    check("t5 stalls seen", stall_cnt > 0, 1);
    check("t5 stall stability", stall_err, 0);
    step(2);

    // Reset during WR_PH
    start(32'h0000_0031, 1'b1);
    step(1);
    check("t6 in WR_PH", {busy, avm_chipselect, avm_address}, {2'b11, 3'd3});
    reset_n = 1'b0;
    #1;
    check("t6 async strobes", {avm_chipselect, avm_write_n, avm_read}, 3'b010);
    check("t6 async busy", busy, 0);
    check("t6 async addr/data", {avm_address, avm_writedata}, 0);
    check("t6 async snap_value", snap_value, 0);
    step(1);
    reset_n = 1'b1;
    step(1);
    wlog.delete();
    start(32'd0, 1'b1);
    step(3);
    check("t6 zero period ignored", {busy, 8'(wlog.size())}, 0);
    start(32'h0000_0031, 1'b1);
    step(4);
    check("t6 restart writes", wlog.size(), 3);
    check("t6 restart ctrl", wlog[2], we(3'd1, 16'h0007));
    wait_for(0, 60, "t6 tick", n);
    check("t6 tick_count", tick_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl_master.md
# timer_ctrl_master

Avalon-MM initiator that owns the interval timer's 16-bit `s1` register port (status, control, period_l/h, snap_l/h at word addresses 0–5) and runs it without CPU involvement.
- Takes a period and start/stop/snapshot requests from local logic, programs the timer, and services its `irq` by clearing status.
- Emits one `tick` pulse per timeout and returns 32-bit counter snapshots.
- Sits between a hardware sequencer (e.g. a sample-rate generator) and the timer slave.

## Interface
- `READ_LATENCY`, 1: cycles from address-phase acceptance to valid `avm_readdata` (timer slave = 1).
- `TICK_W`, 16: width of `tick_count`.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cfg_period` in 32: timer load value; sampled on accepted `cfg_start`.
- `cfg_continuous` in 1: 1 = periodic, 0 = one-shot; sampled with `cfg_period`.
- `cfg_start` in 1: pulse; start sequence (honoured only in IDLE).
- `cfg_stop` in 1: pulse; stop timer (honoured only in RUN).
- `snap_req` in 1: pulse; capture counter (honoured only in RUN).
- `busy` out 1: high in every state except IDLE.
- `tick` out 1: one-cycle pulse per serviced timeout.
- `tick_count` out TICK_W: serviced timeouts since last accepted start; wraps.
- `snap_value` out 32: last snapshot.
- `snap_valid` out 1: one-cycle pulse when `snap_value` updates.
- `irq` in 1: timer interrupt.
- `avm_address` out 3: word address.
- `avm_chipselect` out 1: bus transaction strobe.
- `avm_write_n` out 1: 0 = write.
- `avm_read` out 1: read strobe (ignored by the timer; provided for generic fabrics).
- `avm_writedata` out 16: write data.
- `avm_readdata` in 16: read data.
- `avm_waitrequest` in 1: stall; tie 0 for the timer.

## Operation
- FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, STOP, SNAP_WR, RD_L, RD_H.
- IDLE, `cfg_start`=1, `cfg_period`≠0:
  - Latch period and mode.
  - Clear `tick_count`.
  - Go to WR_PL.
- IDLE, `cfg_period`=0: start ignored.
- WR_PL: write addr 2 = period[15:0]. WR_PH: write addr 3 = period[31:16]. Periods are written before control because a period write stops the timer.
- WR_CTRL: write addr 1 = 0x0007 (continuous) or 0x0005 (one-shot), i.e. START|CONT|ITO.
- RUN priority: `irq` > `cfg_stop` > `snap_req`. Lower-priority pulses arriving in the same cycle are dropped, not queued.
- CLR_ST:
  - Write addr 0 = 0x0000.
  - On acceptance, pulse `tick` and increment `tick_count`.
  - Then return to RUN if continuous, else IDLE.
- STOP: write addr 1 = 0x0008 (STOP, ITO off), then IDLE.
- SNAP_WR: write addr 4 = 0x0000.
- RD_L, RD_H: read addr 4, then addr 5.
- After RD_H data returns, `snap_value` = {hi, lo}, pulse `snap_valid`, return to RUN.
- `irq` arriving during a snapshot is serviced on return to RUN; the timer holds `irq` level, so it is not lost.
- `cfg_start` outside IDLE, and `cfg_stop`/`snap_req` outside RUN, are ignored.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `tick`, `snap_valid`, `avm_chipselect`, `avm_read` = 0.
  - `avm_write_n` = 1.
  - `avm_address`, `avm_writedata`, `tick_count`, `snap_value` = 0.
- All bus outputs are registered.
- A write occupies one cycle, extended while `avm_waitrequest`=1. Address, data and strobes are held stable until accepted.
- Read: address phase accepted in cycle N; `avm_readdata` is captured at the end of cycle N+READ_LATENCY. Chipselect and read are deasserted during the wait.
- Start to timer running: 3 bus cycles (WR_PL, WR_PH, WR_CTRL) after the start is accepted, with no waitrequest.
- Irq to tick: `irq` sampled high in RUN → CLR_ST write next cycle → `tick` asserted in the cycle after the write is accepted. `irq` is low by then, so no double count.
- Snapshot latency with READ_LATENCY=1: 1 write + 2×2 read cycles, so `snap_valid` 5 cycles after leaving RUN.
- Asynchronous reset mid-transaction:
  - Drops the bus strobes immediately.
  - Timer state is not restored; the timer has its own reset.

## Structure
- Shared package: timer register word addresses (0–5), control bit positions (ITO=0, CONT=1, START=2, STOP=3), state enum.
- Single module, no sub-module. The bus-cycle handler (hold-until-accepted, read-latency counter) is an inline process.

## Test plan
- Start, period 0x0000_0031, continuous:
  - Writes observed in order: a2=0x0031, a3=0x0000, a1=0x0007.
  - Ticks spaced 50 cycles apart.
  - After 3 irqs, `tick_count`=3.
- One-shot, period 10: one tick, then `busy`=0. Further `irq` is ignored and `tick_count` stays 1.
- `snap_req` with the timer model mid-count at 0x0001_2345:
  - Sequence: write a4, read a4, read a5.
  - `snap_value`=0x0001_2345 with a one-cycle `snap_valid`.
- Same-cycle `irq` and `cfg_stop`:
  - CLR_ST is performed first and `tick` pulses.
  - The stop is dropped; the timer keeps running (continuous).
- Random `avm_waitrequest` (50%): every write is held stable until accepted, and the sequence and values are unchanged.
- `reset_n` low during WR_PH:
  - All outputs take reset values asynchronously.
  - After release, `cfg_period`=0 start is ignored.
  - A valid start then succeeds.
